fetch_redirect_ctrl: RTL

- Front-end fetch sequencer between the PC redirect sources (WB exception/ertn, EX branch resolve, ID predictor) and the icache request port.
- Owns the fetch PC and arbitrates redirects by fixed priority.
- Issues one outstanding icache request at a time with a valid/ready handshake.
- Discards stale responses after a redirect and keeps branch/mispredict statistics counters.

---
 rtl/fetch_redirect_ctrl_if.sv | 32 +++
 rtl/fetch_redirect_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: redirect, icache handshake and statistics signals of the fetch sequencer
interface fetch_redirect_ctrl_if;
    logic        wb_redirect_valid;
    logic [31:0] wb_redirect_pc;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        id_redirect_valid;
    logic [31:0] id_redirect_pc;
    logic        ex_branch_valid;
    logic        ex_mispredict;
    logic        ibuf_full;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic        fetch_req_valid;
    logic [31:0] fetch_pc;
    logic        resp_accept;
    logic [31:0] resp_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    modport master (
        output wb_redirect_valid, wb_redirect_pc, ex_redirect_valid, ex_redirect_pc,
               id_redirect_valid, id_redirect_pc, ex_branch_valid, ex_mispredict,
               ibuf_full, icache_req_ready, icache_resp_valid,
        input  fetch_req_valid, fetch_pc, resp_accept, resp_pc, branch_count, mispredict_count
    );
    modport slave (
        input  wb_redirect_valid, wb_redirect_pc, ex_redirect_valid, ex_redirect_pc,
               id_redirect_valid, id_redirect_pc, ex_branch_valid, ex_mispredict,
               ibuf_full, icache_req_ready, icache_resp_valid,
        output fetch_req_valid, fetch_pc, resp_accept, resp_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC owner with prioritized redirects, single outstanding icache request and branch statistics
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h1C000000,
    parameter int          FETCH_BYTES = 8
) (
    input  logic                 aclk,
    input  logic                 reset,
    fetch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;
    localparam logic [31:0] FB = 32'(FETCH_BYTES);
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] branch_count_q, mispredict_count_q;
    logic        any, req_valid, resp_accept;
    logic [31:0] sel_pc, next_pc;
    assign any = bus.wb_redirect_valid | bus.ex_redirect_valid | bus.id_redirect_valid;
    assign sel_pc = bus.wb_redirect_valid ? bus.wb_redirect_pc :
                    bus.ex_redirect_valid ? bus.ex_redirect_pc : bus.id_redirect_pc;
    assign next_pc = (fetch_pc_q & ~(FB - 32'd1)) + FB;
    assign req_valid = (state_q == S_REQ) && !bus.ibuf_full && !any;
    assign bus.fetch_req_valid = req_valid;
    assign bus.fetch_pc = fetch_pc_q;
    assign bus.resp_accept = resp_accept;
    assign bus.resp_pc = fetch_pc_q;
    assign bus.branch_count = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
    // next-state: redirects always win; a redirect while waiting either drops a coincident response or parks the target until the stale one returns
    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d = pend_pc_q;
        resp_accept = 1'b0;
        case (state_q)
            S_REQ: begin
                if (any) fetch_pc_d = sel_pc;
                else if (req_valid && bus.icache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (any && bus.icache_resp_valid) begin
                    fetch_pc_d = sel_pc;
                    state_d = S_REQ;
                end else if (any) begin
                    pend_pc_d = sel_pc;
                    pend_valid_d = 1'b1;
                    state_d = S_DISCARD;
                end else if (bus.icache_resp_valid) begin
                    resp_accept = 1'b1;
                    fetch_pc_d = next_pc;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (any) pend_pc_d = sel_pc;
                if (bus.icache_resp_valid) begin
                    fetch_pc_d = any ? sel_pc : pend_pc_q;
                    pend_valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
    // sequencer state registers
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= S_REQ;
            fetch_pc_q <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q <= pend_pc_d;
        end
    end
    // branch statistics, independent of the fetch sequencer
    always_ff @(posedge aclk) begin
        if (reset) begin
            branch_count_q <= '0;
            mispredict_count_q <= '0;
        end else if (bus.ex_branch_valid) begin
            branch_count_q <= branch_count_q + 32'd1;
            mispredict_count_q <= mispredict_count_q + {31'd0, bus.ex_mispredict};
        end
    end
endmodule
